// File: rtl/spi_master_xfer_if.sv
// spi_master_xfer_if: controller, SPI pin and result signals of the single-byte SPI master.
// The master modport is the SPI master block itself; slave is everything around it.
interface spi_master_xfer_if #(parameter int DATA_W = 8);
    logic [1:0]        freq_control;
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              miso;
    logic              cs_bar;
    logic              sclk;
    logic              mosi;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_done;
    logic              busy;
    modport master (
        input  freq_control, start, tx_data, miso,
        output cs_bar, sclk, mosi, rx_data, rx_valid, tx_done, busy
    );
    modport slave (
        output freq_control, start, tx_data, miso,
        input  cs_bar, sclk, mosi, rx_data, rx_valid, tx_done, busy
    );
endinterface

// File: rtl/spi_master_xfer.sv
// spi_master_xfer: single-transfer SPI master, mode 0, MSB first.
// Frame is SETUP (H) + 2*DATA_W sclk half-periods (H each) + HOLD (H), then a 1-cycle DONE.
module spi_master_xfer #(
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic reset,
    spi_master_xfer_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam int EDGES = 2 * DATA_W;
    localparam int EW    = $clog2(EDGES + 1);

    logic [2:0]        state_q, state_d;
    logic [2:0]        h_q, h_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              cs_bar_q, cs_bar_d;
    logic              sclk_q, sclk_d;
    logic              busy_q, busy_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_done_q, tx_done_d;
    logic [2:0]        h_sel;
    logic              accept;
    logic              tick;

    // h_q/cnt_q hold H-1 so a phase ends when the down-counter reaches zero
    assign h_sel  = bus.freq_control[1] ? (bus.freq_control[0] ? 3'd7 : 3'd3)
                                        : {2'b00, bus.freq_control[0]};
    assign accept = (state_q == S_IDLE || state_q == S_DONE) && bus.start;
    assign tick   = cnt_q == 3'd0;

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        cnt_d      = tick ? h_q : cnt_q - 3'd1;
        edge_d     = edge_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        cs_bar_d   = cs_bar_q;
        sclk_d     = sclk_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        tx_done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = accept ? S_SETUP : S_IDLE;
                if (accept) begin
                    h_d      = h_sel;
                    cnt_d    = h_sel;
                    edge_d   = '0;
                    tx_sh_d  = bus.tx_data;
                    rx_sh_d  = '0;
                    cs_bar_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    state_d = S_XFER;
                    sclk_d  = 1'b1;
                    edge_d  = EW'(1);
                    rx_sh_d = {rx_sh_q[DATA_W-2:0], bus.miso};
                end
            end
            S_XFER: begin
                if (tick && edge_q == EW'(EDGES)) begin
                    state_d = S_HOLD;
                end else if (tick) begin
                    edge_d = edge_q + EW'(1);
                    sclk_d = ~sclk_q;
                    rx_sh_d = sclk_q ? rx_sh_q : {rx_sh_q[DATA_W-2:0], bus.miso};
                    // the last falling edge leaves bit 0 on mosi instead of shifting
                    tx_sh_d = (sclk_q && edge_q != EW'(EDGES - 1)) ? {tx_sh_q[DATA_W-2:0], 1'b0} : tx_sh_q;
                end
            end
            S_HOLD: begin
                if (tick) begin
                    state_d    = S_DONE;
                    cs_bar_d   = 1'b1;
                    busy_d     = 1'b0;
                    tx_sh_d    = '0;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    tx_done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            h_q        <= '0;
            cnt_q      <= '0;
            edge_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            cs_bar_q   <= 1'b1;
            sclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            cs_bar_q   <= cs_bar_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // mosi is the shift register MSB, which is cleared outside a frame
    assign bus.cs_bar   = cs_bar_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = tx_sh_q[DATA_W-1];
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_done  = tx_done_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_spi_master_xfer.sv
// tb_spi_master_xfer: directed transfers with a scoreboard of expected frames.
// A negedge monitor measures each frame and checks it against the queue head on rx_valid.
module tb_spi_master_xfer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_master_xfer_if #(.DATA_W(8)) bus ();
    spi_master_xfer #(.DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [7:0] rx;
        logic [7:0] pat;
        int         h;
        int         gap;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int tests = 0;
    int errors = 0;
    bit loop = 1'b1;
    logic [7:0] slave_pat = 8'h00;
    logic [7:0] slave_sh = 8'h00;
    logic sl_prev = 1'b0;
    int cs_cnt, rises, hi_run, lo_run, hi_min, hi_max, lo_min, lo_max, hi_gap, gap;
    logic prev_sclk, prev_cs;
    logic [7:0] pat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task clr();
        cs_cnt = 0; rises = 0; hi_run = 0; lo_run = 0; pat = 8'h00;
        hi_min = 9999; hi_max = 0; lo_min = 9999; lo_max = 0;
    endtask

    // slave model: loopback, or shift slave_pat out MSB first, advancing on sclk falls
    always @(negedge clk) begin
        if (bus.cs_bar !== 1'b0) slave_sh = slave_pat;
        else if (sl_prev && !bus.sclk) slave_sh = {slave_sh[6:0], 1'b0};
        sl_prev = bus.sclk;
        bus.miso = loop ? bus.mosi : slave_sh[7];
    end

    always @(negedge clk) begin
        if (reset) begin
            clr();
            hi_gap = 0; gap = -1; prev_sclk = 1'b0; prev_cs = 1'b1;
        end else begin
            if (!bus.cs_bar) cs_cnt++;
            if (bus.cs_bar && !prev_cs) hi_gap = 1;
            else if (bus.cs_bar) hi_gap++;
            if (!bus.cs_bar && prev_cs) gap = hi_gap;
            if (bus.sclk) begin
                if (!prev_sclk) begin
                    rises++;
                    pat = {pat[6:0], bus.mosi};
                    if (lo_run < lo_min) lo_min = lo_run;
                    if (lo_run > lo_max) lo_max = lo_run;
                    lo_run = 0;
                end
                hi_run++;
            end else begin
                if (prev_sclk) begin
                    if (hi_run < hi_min) hi_min = hi_run;
                    if (hi_run > hi_max) hi_max = hi_run;
                    hi_run = 0;
                end
                if (!bus.cs_bar) lo_run++;
            end
            if (bus.rx_valid || bus.tx_done) chk("tx_done_with_rx_valid", bus.tx_done, bus.rx_valid);
            if (bus.rx_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rx_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rx_data", bus.rx_data, e.rx);
                    chk("done_outputs", {bus.busy, bus.cs_bar, bus.sclk, bus.mosi}, 4'b0100);
                    chk("mosi_pattern", pat, e.pat);
                    chk("cs_low_cycles", cs_cnt, 18 * e.h);
                    chk("sclk_rises", rises, 8);
                    chk("sclk_half_periods", {hi_min == e.h, hi_max == e.h, lo_min == e.h, lo_max == e.h}, 4'hF);
                    if (e.gap >= 0) chk("cs_high_gap", gap, e.gap);
                end
                clr();
            end
            prev_sclk = bus.sclk;
            prev_cs = bus.cs_bar;
        end
    end

    task automatic issue(input logic [1:0] fc, input logic [7:0] tx, input logic [7:0] rx, input int g);
        @(negedge clk);
        bus.freq_control = fc;
        bus.tx_data = tx;
        bus.start = 1'b1;
        q.push_back('{rx: rx, pat: tx, h: 1 << fc, gap: g});
        @(negedge clk);
        bus.start = 1'b0;
        chk("accept_outputs", {bus.cs_bar, bus.busy, bus.mosi}, {2'b01, tx[7]});
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.rx_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", n < 2000, 1);
        @(negedge clk);
    endtask

    initial begin
        int act, r, n;
        logic ps;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.freq_control = 2'b00;
        bus.tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.cs_bar, bus.sclk, bus.mosi, bus.rx_valid, bus.tx_done, bus.busy}, 6'b100000);
        chk("reset_rx_data", bus.rx_data, 0);
        reset = 1'b0;
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.sclk !== 1'b0 || bus.cs_bar !== 1'b1 || bus.busy !== 1'b0 || bus.mosi !== 1'b0 ||
                bus.rx_valid !== 1'b0 || bus.tx_done !== 1'b0 || bus.rx_data !== 8'h00) act++;
        end
        chk("idle_quiet_cycles", act, 0);

        loop = 1'b1;
        issue(2'b00, 8'hA5, 8'hA5, -1);
        wait_done();

        loop = 1'b0;
        slave_pat = 8'h3C;
        issue(2'b11, 8'h00, 8'h3C, -1);
        wait_done();

        loop = 1'b1;
        issue(2'b01, 8'h5A, 8'h5A, -1);
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        bus.tx_data = 8'hFF;
        bus.freq_control = 2'b11;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();

        @(negedge clk);
        bus.freq_control = 2'b00;
        bus.tx_data = 8'h81;
        bus.start = 1'b1;
        q.push_back('{rx: 8'h81, pat: 8'h81, h: 1, gap: -1});
        q.push_back('{rx: 8'h7E, pat: 8'h7E, h: 1, gap: 1});
        @(negedge clk);
        bus.tx_data = 8'h7E;
        wait_done();
        bus.start = 1'b0;
        wait_done();

        @(negedge clk);
        bus.freq_control = 2'b00;
        bus.tx_data = 8'h96;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        r = 0; n = 0; ps = bus.sclk;
        while (r < 4 && n < 500) begin
            @(negedge clk);
            if (bus.sclk && !ps) r++;
            ps = bus.sclk;
            n++;
        end
        chk("fourth_rise_seen", r, 4);
        reset = 1'b1;
        #1;
        chk("abort_outputs", {bus.cs_bar, bus.sclk, bus.busy, bus.rx_valid, bus.tx_done}, 5'b10000);
        chk("abort_rx_data", bus.rx_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(2'b00, 8'hC3, 8'hC3, -1);
        wait_done();

        issue(2'b10, 8'h3C, 8'h3C, -1);
        wait_done();

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
